// File: rtl/axi_llc_way_rsp_buf_pkg.sv
// Shared LLC configuration type, default way-response buffer depth and default payload types.
// The default payload types let the buffer elaborate on its own.
package axi_llc_way_rsp_buf_pkg;

  typedef struct packed {
    logic [7:0]  SetAssociativity;
    logic [15:0] NumLines;
    logic [15:0] NumBlocks;
  } llc_cfg_t;

  localparam int unsigned WayRspBufDepth = 4;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
  } way_inp_dflt_t;

  typedef logic [31:0] way_oup_dflt_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axi_llc_way_rsp_buf_fifo.sv
// Registered-output (non fall-through) FIFO holding way responses for the unit.
// The parent guarantees it never pushes into a full FIFO without popping, nor pops an empty one.
module axi_llc_way_rsp_buf_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         dtype = logic,
  parameter int unsigned CntW  = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            testmode_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] usage_o,
  input  dtype            data_i,
  input  logic            push_i,
  output dtype            data_o,
  input  logic            pop_i
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  dtype            r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_usage;

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + PtrW'(1);
      if (pop_i)  r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   r_usage <= r_usage + CntW'(1);
        2'b01:   r_usage <= r_usage - CntW'(1);
        default: r_usage <= r_usage;
      endcase
    end
  end

  assign full_o  = (r_usage == CntW'(Depth));
  assign empty_o = (r_usage == '0);
  assign usage_o = r_usage;
  assign data_o  = r_mem[r_rd_ptr];

  assert property (@(posedge clk_i) disable iff (!rst_ni || testmode_i) !(push_i && full_o && !pop_i));
  assert property (@(posedge clk_i) disable iff (!rst_ni || testmode_i) !(pop_i && empty_o));

endmodule

// File: rtl/axi_llc_way_rsp_buf.sv
// Credit-gated way response buffer: a read reaches the ways only with a reserved slot, and
// every way response is accepted the cycle it is valid so the unit never stalls the ways.
module axi_llc_way_rsp_buf
  import axi_llc_way_rsp_buf_pkg::*;
#(
  parameter llc_cfg_t    Cfg       = llc_cfg_t'{default: '0},
  parameter int unsigned Depth     = WayRspBufDepth,
  parameter type         way_inp_t = way_inp_dflt_t,
  parameter type         way_oup_t = way_oup_dflt_t,
  localparam int unsigned CntW     = cnt_width(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            test_i,
  input  way_inp_t        req_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  output way_inp_t        req_o,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  input  way_oup_t        rsp_i,
  input  logic            rsp_valid_i,
  output logic            rsp_ready_o,
  output way_oup_t        rsp_o,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [CntW-1:0] credits_o,
  output logic            err_o
);

  logic [CntW-1:0] r_outst;
  logic            r_err;
  logic [CntW-1:0] w_stored;
  logic [CntW-1:0] w_credits;
  logic            w_gate;
  logic            w_read_hs;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;

  // Reservations are counted at issue, so outstanding plus stored can never exceed Depth.
  assign w_credits   = CntW'(Depth) - r_outst - w_stored;
  assign w_gate      = req_i.we | (w_credits != '0);
  assign req_o       = req_i;
  assign req_valid_o = req_valid_i & w_gate;
  assign req_ready_o = req_ready_i & w_gate;
  assign w_read_hs   = req_valid_o & req_ready_i & ~req_i.we;

  // A response on a full FIFO is still taken when the unit pops in the same cycle.
  assign w_pop       = rsp_valid_o & rsp_ready_i;
  assign w_push      = rsp_valid_i & (r_outst != '0) & (~w_full | w_pop);
  assign rsp_ready_o = 1'b1;
  assign rsp_valid_o = ~w_empty;
  assign credits_o   = w_credits;
  assign err_o       = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outst <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case ({w_read_hs, w_push})
        2'b10:   r_outst <= r_outst + CntW'(1);
        2'b01:   r_outst <= r_outst - CntW'(1);
        default: r_outst <= r_outst;
      endcase
      if (rsp_valid_i && !w_push) r_err <= 1'b1;
    end
  end

  axi_llc_way_rsp_buf_fifo #(
    .Depth (Depth),
    .dtype (way_oup_t),
    .CntW  (CntW)
  ) i_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .testmode_i (test_i),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .usage_o    (w_stored),
    .data_i     (rsp_i),
    .push_i     (w_push),
    .data_o     (rsp_o),
    .pop_i      (w_pop)
  );

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (int'(r_outst) + int'(w_stored)) <= int'(Depth));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req_valid_o && !req_i.we && (w_credits == '0)));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_o && !rsp_ready_i) |=> $stable(rsp_o));

endmodule

// File: tb/tb_axi_llc_way_rsp_buf.sv
// Directed bench for the credit-gated way response buffer at Depth=4.
module tb_axi_llc_way_rsp_buf;
  import axi_llc_way_rsp_buf_pkg::*;

  localparam int unsigned D = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          test_i;
  way_inp_dflt_t req_i;
  logic          req_valid_i;
  logic          req_ready_o;
  way_inp_dflt_t req_o;
  logic          req_valid_o;
  logic          req_ready_i;
  way_oup_dflt_t rsp_i;
  logic          rsp_valid_i;
  logic          rsp_ready_o;
  way_oup_dflt_t rsp_o;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [2:0]    credits_o;
  logic          err_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  axi_llc_way_rsp_buf #(
    .Depth     (D),
    .way_inp_t (way_inp_dflt_t),
    .way_oup_t (way_oup_dflt_t)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .test_i      (test_i),
    .req_i       (req_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_o       (req_o),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .rsp_i       (rsp_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_ready_o (rsp_ready_o),
    .rsp_o       (rsp_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .credits_o   (credits_o),
    .err_o       (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic way_inp_dflt_t rd(input int a);
    way_inp_dflt_t r;
    r.we   = 1'b0;
    r.addr = a[15:0];
    r.data = '0;
    return r;
  endfunction

  initial begin
    int exp_cred [7];
    int got;
    way_inp_dflt_t wr;
    exp_cred = '{0, 1, 1, 1, 2, 3, 4};

    // Reset
    rst_ni = 1'b0; test_i = 1'b0; req_i = rd(0); req_valid_i = 1'b0; req_ready_i = 1'b1;
    rsp_i = '0; rsp_valid_i = 1'b0; rsp_ready_i = 1'b0;
    #2;
    chk("rst_credits", credits_o, D);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rsp_ready", rsp_ready_o, 1);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // T1: unit stalled, 6 read attempts, ways answer one cycle after issue
    for (int i = 0; i < 6; i++) begin
      req_valid_i = 1'b1;
      req_i       = rd((i < 4) ? i : 4);
      rsp_valid_i = (i >= 1 && i <= 4);
      rsp_i       = 32'(100 + i - 1);
      #1;
      chk($sformatf("t1_credits_%0d", i), credits_o, (i < 4) ? D - i : 0);
      chk($sformatf("t1_req_ready_%0d", i), req_ready_o, (i < 4));
      chk($sformatf("t1_req_valid_%0d", i), req_valid_o, (i < 4));
      chk($sformatf("t1_rsp_ready_%0d", i), rsp_ready_o, 1);
      chk($sformatf("t1_rsp_valid_%0d", i), rsp_valid_o, (i >= 2));
      if (i >= 2) chk($sformatf("t1_rsp_hold_%0d", i), rsp_o, 100);
      tick();
    end

    // T2: unit drains; reads 5 and 6 get in as credits come back
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      req_valid_i = (k < 3);
      req_i       = rd((k < 2) ? 4 : 5);
      rsp_valid_i = (k == 2 || k == 3);
      rsp_i       = 32'(104 + k - 2);
      #1;
      chk($sformatf("t2_credits_%0d", k), credits_o, exp_cred[k]);
      chk($sformatf("t2_rsp_valid_%0d", k), rsp_valid_o, (k < 6));
      if (k < 6) chk($sformatf("t2_rsp_data_%0d", k), rsp_o, 100 + k);
      if (k < 3) chk($sformatf("t2_req_ready_%0d", k), req_ready_o, (k != 0));
      tick();
    end

    // T3: exhaust credits with reads, then a write still passes
    rsp_valid_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      req_valid_i = 1'b1;
      req_i       = rd(16 + j);
      #1;
      chk($sformatf("t3_read_ready_%0d", j), req_ready_o, 1);
      tick();
    end
    wr.we = 1'b1; wr.addr = 16'h0055; wr.data = 32'hCAFE_F00D;
    req_i = wr;
    #1;
    chk("t3_credits_zero", credits_o, 0);
    chk("t3_wr_valid", req_valid_o, 1);
    chk("t3_wr_ready", req_ready_o, 1);
    chk("t3_wr_passthru", req_o, wr);
    tick();
    req_i = rd(20);
    #1;
    chk("t3_credits_after_wr", credits_o, 0);
    chk("t3_rd_blocked_valid", req_valid_o, 0);
    chk("t3_rd_blocked_ready", req_ready_o, 0);
    req_valid_i = 1'b0;
    for (int j = 0; j < 6; j++) begin
      rsp_valid_i = (j < 4);
      rsp_i       = 32'(200 + j);
      #1;
      if (j >= 1 && j <= 4) chk($sformatf("t3_rsp_data_%0d", j), rsp_o, 200 + j - 1);
      if (j == 4) chk("t3_credits_j4", credits_o, 3);
      if (j == 5) chk("t3_credits_j5", credits_o, 4);
      if (j == 5) chk("t3_rsp_empty", rsp_valid_o, 0);
      tick();
    end

    // T4: 100-read stream, ways latency 1, unit always ready
    got = 0;
    for (int c = 0; c < 103; c++) begin
      req_valid_i = (c < 100);
      req_i       = rd(c);
      rsp_valid_i = (c >= 1 && c <= 100);
      rsp_i       = 32'(1000 + c - 1);
      #1;
      if (c < 100) chk($sformatf("t4_req_ready_%0d", c), req_ready_o, 1);
      chk($sformatf("t4_credits_nz_%0d", c), (credits_o != 0), 1);
      if (rsp_valid_o) begin
        chk($sformatf("t4_order_%0d", got), rsp_o, 1000 + got);
        got++;
      end
      tick();
    end
    req_valid_i = 1'b0; rsp_valid_i = 1'b0;
    #1;
    chk("t4_delivered", got, 100);
    chk("t4_err", err_o, 0);
    chk("t4_credits_idle", credits_o, D);

    // T5: spurious response with nothing outstanding
    rsp_valid_i = 1'b1; rsp_i = 32'h0000_DEAD;
    tick();
    rsp_valid_i = 1'b0;
    #1;
    chk("t5_err_set", err_o, 1);
    chk("t5_rsp_valid", rsp_valid_o, 0);
    chk("t5_credits", credits_o, D);
    tick();
    chk("t5_err_sticky", err_o, 1);

    // T6: 3 buffered + 1 outstanding, then asynchronous reset mid-cycle
    rsp_ready_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      req_valid_i = 1'b1;
      req_i       = rd(40 + j);
      rsp_valid_i = (j >= 1);
      rsp_i       = 32'(300 + j - 1);
      #1;
      chk($sformatf("t6_credits_%0d", j), credits_o, D - j);
      tick();
    end
    req_valid_i = 1'b0; rsp_valid_i = 1'b0;
    #1;
    chk("t6_pre_credits", credits_o, 0);
    chk("t6_pre_rsp_valid", rsp_valid_o, 1);
    chk("t6_pre_rsp_data", rsp_o, 300);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_rsp_valid", rsp_valid_o, 0);
    chk("t6_rst_credits", credits_o, D);
    chk("t6_rst_err", err_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("t6_post_credits", credits_o, D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
